// File: rtl/inv_share_pkg.sv
// Shared constants, index-width helper and stage record for the shared inverter scheduler.
package inv_share_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREQ  = 4;

    function automatic int idw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDW = idw_of(DEF_NREQ);

    typedef struct packed {
        logic                 valid;
        logic [DEF_IDW-1:0]   id;
        logic [DEF_WIDTH-1:0] data;
    } stage_t;

endpackage

// File: rtl/inv_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to the lowest index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    logic           hi_any;
    logic           lo_any;
    logic [IDW-1:0] hi_w;
    logic [IDW-1:0] lo_w;

    // Upper search covers ptr..NREQ-1; lower search is the wrap-around fallback.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_w   = '0;
        lo_w   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !hi_any && (IDW'(i) >= ptr)) begin
                hi_any = 1'b1;
                hi_w   = IDW'(i);
            end
            if (req[i] && !lo_any) begin
                lo_any = 1'b1;
                lo_w   = IDW'(i);
            end
        end
    end

    assign any    = hi_any || lo_any;
    assign winner = hi_any ? hi_w : lo_w;

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = enable && any && (IDW'(i) == winner);
        end
    end

endmodule

// File: rtl/lpm_inv.sv
// Codebase bitwise inverter primitive, LPM-style port naming.
module lpm_inv #(
    parameter int lpm_width = 1
) (
    input  logic [lpm_width-1:0] data,
    output logic [lpm_width-1:0] result
);

    assign result = ~data;

endmodule

// File: rtl/inv_share_sched.sv
// Shares one lpm_inv among NREQ requesters: round-robin issue into S1, inverted result held in S2.
module inv_share_sched
    import inv_share_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = idw_of(NREQ)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic [IDW-1:0]    rsp_id,
    input  logic              rsp_ready,
    output logic              busy
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [IDW-1:0]   s1_id;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic [IDW-1:0]   s2_id;
    logic [IDW-1:0]   ptr;

    logic             s2_free;
    logic             s1_free;
    logic             accept;
    logic             s1_to_s2;
    logic             arb_any;
    logic [IDW-1:0]   winner;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] inv_data;

    assign s2_free  = !s2_valid || rsp_ready;
    assign s1_free  = !s1_valid || s2_free;
    assign accept   = arb_any && s1_free;
    assign s1_to_s2 = s1_valid && s2_free;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .enable (s1_free),
        .grant  (req_ready),
        .winner (winner),
        .any    (arb_any)
    );

    // Operand mux keyed on the encoded winner; only feeds S1, never an output.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == winner) begin
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    lpm_inv #(
        .lpm_width (WIDTH)
    ) u_inv (
        .data   (s1_data),
        .result (inv_data)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            ptr      <= '0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_free);
            s2_valid <= s1_to_s2 || (s2_valid && !rsp_ready);
            if (accept) begin
                s1_data <= sel_data;
                s1_id   <= winner;
                if (int'(winner) == NREQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= winner + 1'b1;
                end
            end
            if (s1_to_s2) begin
                s2_data <= inv_data;
                s2_id   <= s1_id;
            end
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;
    assign busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_inv_share_sched.sv
// Bench for inv_share_sched: grant-order scoreboard model checked every cycle, plus pinned literal cases.
module tb_inv_share_sched;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [127:0] req_data = '0;
    logic [3:0]   req_ready;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_id;
    logic         rsp_ready = 1'b0;
    logic         busy;

    logic         v1 = 1'b0;
    logic         d1 = 1'b0;
    logic         r1 = 1'b0;
    logic         ready1;
    logic         rspv1;
    logic         rspd1;
    logic         rspid1;
    logic         busy1;

    int tests = 0;
    int fails = 0;
    int stim_cnt = 0;
    int edges = 0;

    typedef struct {
        int          t;
        int          id;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   mptr = 0;

    inv_share_sched #(.WIDTH(32), .NREQ(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    inv_share_sched #(.WIDTH(1), .NREQ(1)) dut1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (v1),
        .req_data  (d1),
        .req_ready (ready1),
        .rsp_valid (rspv1),
        .rsp_data  (rspd1),
        .rsp_id    (rspid1),
        .rsp_ready (r1),
        .busy      (busy1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edges++;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pipeline seen as an ordered list of accepted operands; the head is visible once it has
    // survived one full edge after its accept, and a new accept needs room for at most two in flight.
    always @(negedge reset_n) begin
        q.delete();
        mptr = 0;
    end

    int   m_w;
    bit   m_any;
    bit   m_vis;
    bit   m_pop;
    bit   m_free;
    int   m_occ;
    logic [3:0] m_ready;
    ent_t m_ent;

    always @(negedge clock) begin
        m_vis = (q.size() > 0) && (q[0].t < edges);
        m_pop = m_vis && rsp_ready;
        m_occ = q.size() - (m_pop ? 1 : 0);
        m_free = m_occ < 2;
        m_any = 1'b0;
        m_w = 0;
        for (int k = 0; k < 4; k++) begin
            if (!m_any && req_valid[(mptr + k) % 4]) begin
                m_any = 1'b1;
                m_w = (mptr + k) % 4;
            end
        end
        m_ready = (m_any && m_free) ? (4'b0001 << m_w) : 4'b0000;

        checkOutput("req_ready", 64'(req_ready), 64'(m_ready));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_vis));
        checkOutput("busy", 64'(busy), 64'(q.size() > 0));
        if (m_vis) begin
            checkOutput("rsp_data", 64'(rsp_data), 64'(q[0].data));
            checkOutput("rsp_id", 64'(rsp_id), 64'(q[0].id));
        end
        if (!reset_n) begin
            checkOutput("rst_rsp_data", 64'(rsp_data), 64'h0);
            checkOutput("rst_rsp_id", 64'(rsp_id), 64'h0);
        end else begin
            if (m_pop) q.delete(0);
            if (m_any && m_free) begin
                m_ent.t = edges + 1;
                m_ent.id = m_w;
                m_ent.data = ~req_data[m_w*32 +: 32];
                q.push_back(m_ent);
                mptr = (m_w + 1) % 4;
            end
        end
    end

    function automatic logic [127:0] genData(input int n);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) begin
            d[i*32 +: 32] = 32'h1000_0000 * (i + 1) + 32'(n * 16 + i);
        end
        return d;
    endfunction

    task automatic applyStimulus(input logic [3:0] v, input logic [127:0] d, input logic rr);
        @(posedge clock);
        #1;
        req_valid = v;
        req_data  = d;
        rsp_ready = rr;
        stim_cnt++;
    endtask

    logic [3:0] pat_v [8] = '{4'b1010, 4'b1010, 4'b0101, 4'b1111, 4'b0011, 4'b1000, 4'b0000, 4'b1111};
    logic       pat_r [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        repeat (2) @(posedge clock);
        #2;
        checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("reset_busy", 64'(busy), 64'h0);
        @(posedge clock);
        #1 reset_n = 1'b1;

        // Single request from requester 2
        applyStimulus(4'b0100, {32'h0, 32'h0000_FFFF, 64'h0}, 1'b1);
        #1 checkOutput("single_ready", 64'(req_ready), 64'h4);
        applyStimulus(4'b0000, '0, 1'b1);
        applyStimulus(4'b0000, '0, 1'b1);
        #1;
        checkOutput("single_rsp_valid", 64'(rsp_valid), 64'h1);
        checkOutput("single_rsp_data", 64'(rsp_data), 64'hFFFF_0000);
        checkOutput("single_rsp_id", 64'(rsp_id), 64'h2);
        applyStimulus(4'b0000, '0, 1'b1);
        #1 checkOutput("single_busy_low", 64'(busy), 64'h0);

        // Round robin with all requesters active; ptr sits at 3 after the single request
        applyStimulus(4'b1111, genData(stim_cnt), 1'b1);
        #1 checkOutput("rr_first_grant", 64'(req_ready), 64'h8);
        applyStimulus(4'b1111, genData(stim_cnt), 1'b1);
        #1 checkOutput("rr_second_grant", 64'(req_ready), 64'h1);
        repeat (6) applyStimulus(4'b1111, genData(stim_cnt), 1'b1);

        // Backpressure: both stages fill, then drain in order
        repeat (5) applyStimulus(4'b1111, genData(stim_cnt), 1'b0);
        #1;
        checkOutput("stall_ready_zero", 64'(req_ready), 64'h0);
        checkOutput("stall_rsp_valid", 64'(rsp_valid), 64'h1);
        repeat (4) applyStimulus(4'b0000, '0, 1'b1);
        #1 checkOutput("drain_busy_low", 64'(busy), 64'h0);

        // Mixed request patterns with intermittent stalls
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pat_v[i], genData(stim_cnt), pat_r[i]);
        end
        repeat (4) applyStimulus(4'b0000, '0, 1'b1);

        // Reset mid-flight with two entries in the pipeline
        applyStimulus(4'b0110, genData(stim_cnt), 1'b1);
        applyStimulus(4'b0110, genData(stim_cnt), 1'b1);
        @(posedge clock);
        #1 req_valid = 4'b0000;
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        checkOutput("midrst_busy", 64'(busy), 64'h0);
        checkOutput("midrst_rsp_data", 64'(rsp_data), 64'h0);
        #1 reset_n = 1'b1;
        applyStimulus(4'b1100, genData(stim_cnt), 1'b1);
        #1 checkOutput("postrst_grant", 64'(req_ready), 64'h4);
        repeat (4) applyStimulus(4'b0000, '0, 1'b1);

        // WIDTH=1, NREQ=1 instance
        @(posedge clock);
        #1;
        v1 = 1'b1;
        d1 = 1'b1;
        r1 = 1'b1;
        #1 checkOutput("w1_ready", 64'(ready1), 64'h1);
        @(posedge clock);
        #1;
        d1 = 1'b0;
        @(posedge clock);
        #1;
        v1 = 1'b0;
        #1;
        checkOutput("w1_rsp_valid", 64'(rspv1), 64'h1);
        checkOutput("w1_rsp_data", 64'(rspd1), 64'h0);
        checkOutput("w1_rsp_id", 64'(rspid1), 64'h0);
        @(posedge clock);
        #2;
        checkOutput("w1_rsp2_data", 64'(rspd1), 64'h1);
        checkOutput("w1_rsp2_id", 64'(rspid1), 64'h0);
        @(posedge clock);
        #2 checkOutput("w1_busy_low", 64'(busy1), 64'h0);

        repeat (2) @(posedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inv_share_sched.md
# inv_share_sched

Round-robin scheduler sharing one `lpm_inv` datapath instance among NREQ requesters in the GPU. It takes valid/ready requests, grants one per cycle, and pushes the operand through a two-stage registered pipeline with the inverter between the stages. It returns the inverted result tagged with the requester index. Downstream backpressure propagates back to the requesters without dropping or duplicating data.

## Interface
- WIDTH, 32, operand/result width; must be ≥1.
- NREQ, 4, number of requesters; must be ≥1.
- IDW, max(1, $clog2(NREQ)), width of the requester index.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i: requester i presents an operand.
- req_data  in  NREQ*WIDTH  requester i operand at bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  bit i: requester i operand accepted this cycle (combinational).
- rsp_valid  out  1  result available.
- rsp_data  out  WIDTH  ~operand (bitwise inversion).
- rsp_id  out  IDW  index of the originating requester.
- rsp_ready  in  1  consumer accepts the result.
- busy  out  1  either pipeline stage holds a valid entry.

## Operation
- Stage S1 (issue) registers: s1_valid, s1_data, s1_id.
- Stage S2 (output) registers: s2_valid, s2_data = ~s1_data via the lpm_inv instance (lpm_width=WIDTH), s2_id.
- Outputs rsp_valid/rsp_data/rsp_id come directly from the S2 registers.
- s2_free = !s2_valid || rsp_ready.
- s1_free = !s1_valid || s2_free.
- Arbitration: round-robin with pointer ptr (IDW bits).
  - Winner = first i with req_valid[i], searched from ptr upward, modulo NREQ.
  - req_ready[winner] = s1_free; all other req_ready bits are 0.
  - At most one req_ready bit is high per cycle.
- Accept (req_valid[w] && req_ready[w] at the edge): S1 loads req_data slice w and id w; ptr ← (w+1) mod NREQ.
  - With no accept, ptr holds.
  - NREQ=1: ptr stays 0.
- S1→S2 transfer when s1_valid && s2_free; S2 loads ~s1_data and s1_id.
- Removal at the same edge:
  - S1 clears when it transfers to S2 and no new accept occurs in that cycle.
  - S2 clears on rsp_ready with no incoming S1 transfer.
- Simultaneous accept, S1→S2 transfer and response pop are all legal in one cycle, giving full throughput of 1 result/clock.
- Stall (rsp_valid && !rsp_ready): S2 holds rsp_data/rsp_id stable. S1 accepts one more request if it is empty, then req_ready is all 0.
- busy = s1_valid || s2_valid.
- Requesters may drop req_valid without being granted; the arbiter simply re-evaluates the next cycle.
- Requests from one requester are returned in order. Results across requesters are returned in grant order.

## Timing
- Reset (reset_n low, asynchronous): s1_valid=0, s2_valid=0, ptr=0, s1_data/s2_data=0, s1_id/s2_id=0.
  - Hence rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - req_ready = one-hot winner gated by s1_free, so it may be high during reset if req_valid is asserted. Requests presented during reset are not captured.
- Reset deassertion is synchronised by the system. The first accept can occur at the first rising edge after release.
- Reset mid-operation: in-flight entries are discarded with no response; ptr returns to 0.
- Latency: request accepted at edge T → rsp_valid high after edge T+1 (2 cycles accept-to-response-visible), assuming no stall.
- req_ready is combinational from req_valid, ptr, s1_valid, s2_valid and rsp_ready. There is no combinational path from req_data to any output.

## Structure
- Package inv_share_pkg holds:
  - the default WIDTH/NREQ constants;
  - an IDW helper function;
  - a typedef for the {valid, id, data} stage record.
- Sub-module rr_arbiter (NREQ, IDW):
  - inputs: req vector, ptr, enable;
  - outputs: one-hot grant, encoded winner, any.
  - Purely combinational. ptr is owned by inv_share_sched.
- The datapath instantiates the codebase lpm_inv between S1 and S2. No other arithmetic is performed.

## Test plan
- Single request: NREQ=4, requester 2 sends 32'h0000_FFFF with rsp_ready=1 → req_ready[2] high that cycle; rsp_valid two cycles later with rsp_data=32'hFFFF_0000, rsp_id=2; busy falls afterwards.
- Round-robin fairness: all four requesters hold req_valid continuously with rsp_ready=1 → grants in order 0,1,2,3,0,…; one response per clock; ids follow the same order.
- Backpressure: back-to-back requests, then rsp_ready=0 for 5 cycles → S2 and S1 fill and req_ready goes all 0; rsp_data stays constant; on release, both results drain in order with no loss or duplication.
- Simultaneous events: cycle with an accept, an S1→S2 transfer and a pop all at once → one response per cycle; ptr advances by exactly one position past the winner.
- Reset mid-flight: two entries in flight, reset_n pulsed low between edges → rsp_valid, busy and rsp_data drop to 0 immediately; the next grant goes to the lowest active index from ptr=0.
- Edge width: WIDTH=1, NREQ=1 → data 1'b1 returns 1'b0 with rsp_id=0; ptr stays 0.
